// File: rtl/packet_framer_pkg.sv
// packet_framer_pkg: definitions shared by the framer and the matching packet receiver.
package packet_framer_pkg;
    localparam logic [7:0] PACKET_DELIMITER = 8'h00;
endpackage

// File: rtl/packet_framer.sv
// packet_framer: turns a data/valid/ready/last packet stream into a UART byte stream
// terminated by one delimiter per packet, dropping unrepresentable and over-length beats.
module packet_framer
    import packet_framer_pkg::*;
#(
    parameter int MAX_LEN     = 255,
    parameter int LEN_WIDTH   = $clog2(MAX_LEN + 1),
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [7:0]             packet_data,
    input  logic                   packet_valid,
    output logic                   packet_ready,
    input  logic                   packet_last,
    output logic [7:0]             uart_data,
    output logic                   uart_valid,
    input  logic                   uart_ready,
    output logic                   drop_zero,
    output logic                   drop_overlen,
    output logic [COUNT_WIDTH-1:0] packet_count
);
    typedef enum logic {S_DATA, S_TERM} state_t;

    state_t               r_state;
    logic [LEN_WIDTH-1:0] r_count;
    logic                 w_out_free;
    logic                 w_accept;

    assign w_out_free   = !uart_valid | uart_ready;
    assign packet_ready = (r_state == S_DATA) & w_out_free;
    assign w_accept     = packet_valid & packet_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_DATA;
            r_count      <= '0;
            uart_data    <= PACKET_DELIMITER;
            uart_valid   <= 1'b0;
            drop_zero    <= 1'b0;
            drop_overlen <= 1'b0;
            packet_count <= '0;
        end else begin
            drop_zero    <= 1'b0;
            drop_overlen <= 1'b0;
            // a consumed byte empties the register unless a new load below refills it
            if (w_out_free)
                uart_valid <= 1'b0;
            case (r_state)
                S_DATA: if (w_accept) begin
                    if (packet_data == PACKET_DELIMITER)
                        drop_zero <= 1'b1;
                    else if (r_count == LEN_WIDTH'(MAX_LEN))
                        drop_overlen <= 1'b1;
                    else begin
                        uart_data  <= packet_data;
                        uart_valid <= 1'b1;
                        r_count    <= r_count + 1'b1;
                    end
                    if (packet_last) begin
                        r_count <= '0;
                        r_state <= S_TERM;
                    end
                end
                S_TERM: if (w_out_free) begin
                    uart_data    <= PACKET_DELIMITER;
                    uart_valid   <= 1'b1;
                    packet_count <= packet_count + 1'b1;
                    r_state      <= S_DATA;
                end
                default: r_state <= S_DATA;
            endcase
        end
    end
endmodule

// File: tb/tb_packet_framer.sv
// tb_packet_framer: directed packets, expected UART bytes queued up front and
// checked by an independent negedge monitor.
module tb_packet_framer;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  packet_data = 8'h00;
    logic        packet_valid = 1'b0;
    logic        packet_ready;
    logic        packet_last = 1'b0;
    logic [7:0]  uart_data;
    logic        uart_valid;
    logic        uart_ready = 1'b1;
    logic        drop_zero;
    logic        drop_overlen;
    logic [15:0] packet_count;

    packet_framer #(.MAX_LEN(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .packet_data(packet_data), .packet_valid(packet_valid),
        .packet_ready(packet_ready), .packet_last(packet_last),
        .uart_data(uart_data), .uart_valid(uart_valid), .uart_ready(uart_ready),
        .drop_zero(drop_zero), .drop_overlen(drop_overlen),
        .packet_count(packet_count)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int nz = 0;
    int no = 0;
    int z_cyc = -1;
    int acc_cyc = 0;
    logic [7:0] exp_q[$];
    int out_cyc[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) if (reset_n) begin
        if (drop_zero) begin
            nz++;
            z_cyc = cyc;
        end
        if (drop_overlen) no++;
        if (drop_zero || drop_overlen) chk("drop_exclusive", int'(drop_zero & drop_overlen), 0);
        if (uart_valid && uart_ready) begin
            if (exp_q.size() == 0) chk("unexpected_byte", int'(uart_data) + 256, 0);
            else begin
                chk("uart_byte", int'(uart_data), int'(exp_q.pop_front()));
                out_cyc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        packet_valid = 1'b1;
        packet_data  = d;
        packet_last  = l;
        #1;
        while (!packet_ready && n < 100) begin
            @(posedge clock);
            #2;
            n++;
        end
        if (n >= 100) chk("accept_timeout", 1, 0);
        acc_cyc = cyc + 1;
        step();
        packet_valid = 1'b0;
        packet_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || uart_valid) && n < 100) begin
            step();
            n++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        nz = 0;
        no = 0;
        z_cyc = -1;
        out_cyc.delete();
    endtask

    int first_acc;
    int zero_acc;

    initial begin
        do_reset();
        chk("rst_uart_valid", int'(uart_valid), 0);
        chk("rst_uart_data", int'(uart_data), 0);
        chk("rst_drop_zero", int'(drop_zero), 0);
        chk("rst_drop_overlen", int'(drop_overlen), 0);
        chk("rst_packet_count", int'(packet_count), 0);
        chk("rst_packet_ready", int'(packet_ready), 1);

        // basic packet, ready held high
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h00};
        send(8'h41, 1'b0);
        first_acc = acc_cyc;
        send(8'h42, 1'b0);
        send(8'h43, 1'b1);
        drain();
        chk("t1_first_latency", out_cyc[0], first_acc);
        chk("t1_back_to_back", out_cyc[3] - out_cyc[0], 3);
        chk("t1_packet_count", int'(packet_count), 1);

        // backpressure after first byte
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h00};
        send(8'h41, 1'b0);
        uart_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("t2_hold_data", int'(uart_data), 8'h41);
            chk("t2_hold_valid", int'(uart_valid), 1);
            chk("t2_ready_low", int'(packet_ready), 0);
        end
        step();
        uart_ready = 1'b1;
        send(8'h42, 1'b0);
        send(8'h43, 1'b1);
        drain();
        chk("t2_packet_count", int'(packet_count), 2);

        // embedded zero dropped
        nz = 0;
        exp_q = '{8'h10, 8'h20, 8'h00};
        send(8'h10, 1'b0);
        send(8'h00, 1'b0);
        zero_acc = acc_cyc;
        send(8'h20, 1'b1);
        drain();
        chk("t3_drop_zero_count", nz, 1);
        chk("t3_drop_zero_cycle", z_cyc, zero_acc);
        chk("t3_packet_count", int'(packet_count), 3);

        // over-length truncation with MAX_LEN=4
        no = 0;
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        for (int i = 1; i <= 6; i++) send(8'(i), i == 6);
        drain();
        chk("t4_drop_overlen_count", no, 2);
        chk("t4_byte_counter", int'(dut.r_count), 0);
        chk("t4_packet_count", int'(packet_count), 4);

        // fully dropped packet still delimited
        do_reset();
        exp_q = '{8'h00, 8'h55, 8'h00};
        send(8'h00, 1'b1);
        send(8'h55, 1'b1);
        drain();
        chk("t5_drop_zero_count", nz, 1);
        chk("t5_packet_count", int'(packet_count), 2);

        // async reset mid-packet
        uart_ready = 1'b0;
        send(8'h01, 1'b0);
        chk("t6_valid_before_rst", int'(uart_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_valid", int'(uart_valid), 0);
        chk("t6_async_count", int'(packet_count), 0);
        step();
        reset_n = 1'b1;
        uart_ready = 1'b1;
        step();
        exp_q = '{8'h7E, 8'h00};
        send(8'h7E, 1'b1);
        drain();
        chk("t6_packet_count", int'(packet_count), 1);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
